// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: credit-based initiator for the 12-bit ALU interface.
// Optional build macro ALU_ISSUE_STATS_EN adds issue/overflow counters.
module alu_cmd_issuer #(
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_inst,
    input  logic [11:0] i_cmd_a,
    input  logic [11:0] i_cmd_b,
    output logic        o_alu_valid,
    output logic [2:0]  o_alu_inst,
    output logic [11:0] o_alu_a,
    output logic [11:0] o_alu_b,
    input  logic        i_alu_valid,
    input  logic [11:0] i_alu_data,
    input  logic        i_alu_overflow,
    output logic        o_res_valid,
    input  logic        i_res_ready,
    output logic [11:0] o_res_data,
    output logic        o_res_overflow,
    output logic        o_err_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0] o_stat_issued,
    output logic [15:0] o_stat_ovf
`endif
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam logic [CAW:0] CMD_FULL = CMD_DEPTH[CAW:0];
    localparam logic [RAW:0] RES_FULL = RES_DEPTH[RAW:0];

    logic [2:0]     cmd_inst_q [CMD_DEPTH];
    logic [11:0]    cmd_a_q    [CMD_DEPTH];
    logic [11:0]    cmd_b_q    [CMD_DEPTH];
    logic [CAW-1:0] cmd_wr;
    logic [CAW-1:0] cmd_rd;
    logic [CAW:0]   cmd_cnt;

    logic [12:0]    res_q [RES_DEPTH];
    logic [RAW-1:0] res_wr;
    logic [RAW-1:0] res_rd;
    logic [RAW:0]   res_cnt;
    logic [RAW:0]   res_used;
    logic           inflight;

    logic cmd_acc;
    logic cmd_illegal;
    logic cmd_push;
    logic issue;
    logic res_pop;
    logic unused_alu_valid;

    // The ALU drops valid on overflow but still owes a result, so valid is not used.
    assign unused_alu_valid = i_alu_valid;

    assign o_cmd_ready = (cmd_cnt != CMD_FULL);
    assign cmd_acc     = i_cmd_valid & o_cmd_ready;
    assign cmd_illegal = i_cmd_inst[1];
    assign cmd_push    = cmd_acc & ~cmd_illegal;

    // Slots already promised: stored results plus the one in flight.
    assign res_used = res_cnt + {{RAW{1'b0}}, inflight};
    assign issue    = (cmd_cnt != '0) && (res_used < RES_FULL);

    assign o_alu_valid = issue;
    assign o_alu_inst  = issue ? cmd_inst_q[cmd_rd] : 3'd0;
    assign o_alu_a     = issue ? cmd_a_q[cmd_rd] : 12'd0;
    assign o_alu_b     = issue ? cmd_b_q[cmd_rd] : 12'd0;

    assign o_res_valid    = (res_cnt != '0);
    assign res_pop        = o_res_valid & i_res_ready;
    assign o_res_data     = o_res_valid ? res_q[res_rd][12:1] : 12'd0;
    assign o_res_overflow = o_res_valid ? res_q[res_rd][0] : 1'b0;

    // Command FIFO storage write.
    always_ff @(posedge i_clk) begin
        if (cmd_push) begin
            cmd_inst_q[cmd_wr] <= i_cmd_inst;
            cmd_a_q[cmd_wr]    <= i_cmd_a;
            cmd_b_q[cmd_wr]    <= i_cmd_b;
        end
    end

    // Command FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_wr  <= '0;
            cmd_rd  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
            if (issue)    cmd_rd <= cmd_rd + 1'b1;
            if (cmd_push && !issue)      cmd_cnt <= cmd_cnt + 1'b1;
            else if (!cmd_push && issue) cmd_cnt <= cmd_cnt - 1'b1;
        end
    end

    // Illegal opcode pulse and one-cycle ALU latency tracker.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_illegal <= 1'b0;
            inflight      <= 1'b0;
        end else begin
            o_err_illegal <= cmd_acc & cmd_illegal;
            inflight      <= issue;
        end
    end

    // Result FIFO storage write: capture whatever the ALU returns for an issued op.
    always_ff @(posedge i_clk) begin
        if (inflight) res_q[res_wr] <= {i_alu_data, i_alu_overflow};
    end

    // Result FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_wr  <= '0;
            res_rd  <= '0;
            res_cnt <= '0;
        end else begin
            if (inflight) res_wr <= res_wr + 1'b1;
            if (res_pop)  res_rd <= res_rd + 1'b1;
            if (inflight && !res_pop)      res_cnt <= res_cnt + 1'b1;
            else if (!inflight && res_pop) res_cnt <= res_cnt - 1'b1;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating issue and overflow counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stat_issued <= '0;
            o_stat_ovf    <= '0;
        end else begin
            if (issue && o_stat_issued != 16'hFFFF)
                o_stat_issued <= o_stat_issued + 16'd1;
            if (inflight && i_alu_overflow && o_stat_ovf != 16'hFFFF)
                o_stat_ovf <= o_stat_ovf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench with a behavioural ALU and reference model.
// Build with ALU_ISSUE_STATS_EN to also check the statistics counters.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd_inst;
    logic [11:0] i_cmd_a;
    logic [11:0] i_cmd_b;
    logic        o_alu_valid;
    logic [2:0]  o_alu_inst;
    logic [11:0] o_alu_a;
    logic [11:0] o_alu_b;
    logic        alu_v;
    logic [11:0] alu_d;
    logic        alu_o;
    logic        o_res_valid;
    logic        i_res_ready;
    logic [11:0] o_res_data;
    logic        o_res_overflow;
    logic        o_err_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] o_stat_issued;
    logic [15:0] o_stat_ovf;
`endif

    int total = 0;
    int bad = 0;
    int issues = 0;
    int errs = 0;
    int ovf_seen = 0;
    int res_seen = 0;
    bit err_due = 0;
    logic [12:0] exp_q [$];

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_inst(i_cmd_inst),
        .i_cmd_a(i_cmd_a),
        .i_cmd_b(i_cmd_b),
        .o_alu_valid(o_alu_valid),
        .o_alu_inst(o_alu_inst),
        .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b),
        .i_alu_valid(alu_v),
        .i_alu_data(alu_d),
        .i_alu_overflow(alu_o),
        .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready),
        .o_res_data(o_res_data),
        .o_res_overflow(o_res_overflow),
        .o_err_illegal(o_err_illegal)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .o_stat_issued(o_stat_issued),
        .o_stat_ovf(o_stat_ovf)
`endif
    );

    // Reference: {overflow, data} from signed integer arithmetic.
    function automatic logic [12:0] alu_ref(logic [2:0] op, logic [11:0] a, logic [11:0] b);
        int sa;
        int sb;
        int r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'b000: r = sa + sb;
            3'b001: r = sa - sb;
            3'b100: return {1'b0, ~(a ^ b)};
            default: return {1'b0, (sa < 0) ? 12'd0 : a};
        endcase
        return {(r > 2047 || r < -2048), r[11:0]};
    endfunction

    function automatic bit ovf_of(logic [12:0] x);
        return x[12];
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural ALU: one-cycle latency, valid dropped on overflow, garbage when idle.
    always @(posedge clk) begin
        if (o_alu_valid) begin
            {alu_o, alu_d} <= alu_ref(o_alu_inst, o_alu_a, o_alu_b);
            alu_v <= !ovf_of(alu_ref(o_alu_inst, o_alu_a, o_alu_b));
        end else begin
            alu_d <= 12'($urandom);
            alu_o <= 1'($urandom);
            alu_v <= 1'($urandom);
        end
    end

    // Monitor: scoreboard pushes on accept, pops and compares on result handshake.
    always @(negedge clk) begin
        if (i_rst) begin
            exp_q.delete();
            err_due = 1'b0;
        end else begin
            chk("err_pulse", int'(o_err_illegal), int'(err_due));
            if (o_err_illegal) errs++;
            err_due = i_cmd_valid && o_cmd_ready && i_cmd_inst[1];
            if (i_cmd_valid && o_cmd_ready && !i_cmd_inst[1])
                exp_q.push_back(alu_ref(i_cmd_inst, i_cmd_a, i_cmd_b));
            if (o_alu_valid) issues++;
            else chk("alu_idle_zero", int'({o_alu_inst, o_alu_a, o_alu_b}), 0);
            if (o_res_valid && i_res_ready) begin
                res_seen++;
                if (o_res_overflow) ovf_seen++;
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", int'({o_res_overflow, o_res_data}), -1);
                end else begin
                    chk("res_value", int'({o_res_overflow, o_res_data}),
                        int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic send(logic [2:0] op, logic [11:0] a, logic [11:0] b);
        int n = 0;
        i_cmd_valid = 1'b1;
        i_cmd_inst = op;
        i_cmd_a = a;
        i_cmd_b = b;
        @(negedge clk);
        while (!o_cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_cmd_ready) chk("send_timeout", n, 0);
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_res_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", int'(n < 300), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_cmd_ready"}, int'(o_cmd_ready), 1);
        chk({tag, "_alu_valid"}, int'(o_alu_valid), 0);
        chk({tag, "_alu_bus"}, int'({o_alu_inst, o_alu_a, o_alu_b}), 0);
        chk({tag, "_res_valid"}, int'(o_res_valid), 0);
        chk({tag, "_res_bus"}, int'({o_res_overflow, o_res_data}), 0);
        chk({tag, "_err"}, int'(o_err_illegal), 0);
    endtask

    initial begin
        int i0;
        int e0;
        int o0;
        int r0;
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_inst = 3'd0;
        i_cmd_a = 12'd0;
        i_cmd_b = 12'd0;
        i_res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk);
        #1;

        // Single add latency.
        i_cmd_valid = 1'b1;
        i_cmd_inst = 3'b000;
        i_cmd_a = 12'd5;
        i_cmd_b = 12'd3;
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_alu_valid_t1", int'(o_alu_valid), 1);
        @(negedge clk);
        chk("lat_res_valid_t2", int'(o_res_valid), 0);
        @(negedge clk);
        chk("lat_res_valid_t3", int'(o_res_valid), 1);
        chk("lat_res_data", int'(o_res_data), 8);
        chk("lat_res_ovf", int'(o_res_overflow), 0);
        drain();

        // Overflowing add still delivers, ordering kept.
        o0 = ovf_seen;
        r0 = res_seen;
        send(3'b000, 12'd2047, 12'd1);
        send(3'b000, 12'd100, 12'(-5));
        drain();
        chk("ovf_count", ovf_seen - o0, 1);
        chk("ovf_res_count", res_seen - r0, 2);

        // Credit stall with result backpressure.
        i_res_ready = 1'b0;
        i0 = issues;
        for (int k = 0; k < 8; k++) send(3'b001, 12'(k * 37), 12'(k));
        repeat (5) @(negedge clk);
        chk("credit_issued", issues - i0, 4);
        chk("credit_alu_valid", int'(o_alu_valid), 0);
        chk("credit_cmd_ready", int'(o_cmd_ready), 0);
        @(posedge clk);
        #1 i_res_ready = 1'b1;
        drain();
        chk("credit_all_issued", issues - i0, 8);

        // Illegal opcode is dropped.
        i0 = issues;
        e0 = errs;
        r0 = res_seen;
        send(3'b011, 12'd1, 12'd1);
        repeat (5) @(negedge clk);
        chk("illegal_no_issue", issues - i0, 0);
        chk("illegal_err_pulses", errs - e0, 1);
        chk("illegal_no_result", res_seen - r0, 0);
        @(posedge clk);
        #1;

        // Reset with queued and in-flight work.
        i_res_ready = 1'b0;
        for (int k = 0; k < 7; k++) send(3'b100, 12'(k), 12'hA5A);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        i_res_ready = 1'b1;
        r0 = res_seen;
        repeat (10) @(negedge clk);
        chk("midrst_no_stale", res_seen - r0, 0);
        @(posedge clk);
        #1;

`ifdef ALU_ISSUE_STATS_EN
        send(3'b000, 12'd1, 12'd1);
        send(3'b000, 12'd2047, 12'd1);
        send(3'b000, 12'd3, 12'd4);
        drain();
        chk("stat_issued", int'(o_stat_issued), 3);
        chk("stat_ovf", int'(o_stat_ovf), 1);
`endif

        // Randomized traffic including illegal opcodes and backpressure.
        r0 = res_seen;
        i0 = issues;
        for (int c = 0; c < 400; c++) begin
            i_cmd_valid = ($urandom % 10) < 6;
            i_cmd_inst = 3'($urandom);
            i_cmd_a = 12'($urandom);
            i_cmd_b = 12'($urandom);
            i_res_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        i_cmd_valid = 1'b0;
        i_res_ready = 1'b1;
        drain();
        chk("rand_issue_eq_res", issues - i0, res_seen - r0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
